// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory request controller.
package mem_pkg;

    localparam int unsigned MEM_XLEN = 64;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } mem_state_e;

    // Captured access payload, already reduced to what the memory cycle needs.
    typedef struct packed {
        logic                wen;
        logic                sgn_en;
        logic [MEM_XLEN-1:0] mask;
        logic [MEM_XLEN-1:0] addr;
        logic [MEM_XLEN-1:0] wdata;
    } mem_acc_t;

    // Byte-lane mask for the access size, right-aligned.
    function automatic logic [MEM_XLEN-1:0] size_to_mask(input mem_size_e size);
        logic [MEM_XLEN-1:0] mask;
        case (size)
            SZ_B:    mask = MEM_XLEN'(64'h0000_0000_0000_00FF);
            SZ_H:    mask = MEM_XLEN'(64'h0000_0000_0000_FFFF);
            SZ_W:    mask = MEM_XLEN'(64'h0000_0000_FFFF_FFFF);
            default: mask = '1;
        endcase
        return mask;
    endfunction

    // True when the address is not a multiple of the access size.
    function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = |addr_lo[1:0];
            default: bad = |addr_lo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_mask_gen.sv
// Size decode: byte-lane mask and misalignment flag for an incoming request.
module mem_mask_gen
    import mem_pkg::*;
(
    input  mem_size_e           i_size,
    input  logic [2:0]          i_addr_lo,
    output logic [MEM_XLEN-1:0] o_mask,
    output logic                o_misaligned
);

    // Pure decode, no state.
    always_comb begin
        o_mask       = size_to_mask(i_size);
        o_misaligned = is_misaligned(i_size, i_addr_lo);
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Initiator side of the physical-memory interface: one request in flight,
// alignment check, single-cycle access after LATENCY cycles, buffered response.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned XLEN    = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic            req_signed,
    input  logic [1:0]      req_size,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_en,
    output logic            mem_w_en,
    output logic            mem_signed_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_w_data,
    output logic [XLEN-1:0] mem_r_mask,
    input  logic [XLEN-1:0] mem_r_data
);

    // LATENCY==1 skips WAIT; otherwise WAIT runs LATENCY-1 cycles.
    localparam logic             DIRECT_ACCESS = (LATENCY <= 32'd1);
    localparam logic [CNT_W-1:0] WAIT_INIT     = CNT_W'(LATENCY - 32'd1);

    mem_state_e          r_state;
    mem_state_e          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    mem_acc_t            r_acc;
    mem_acc_t            w_acc_req;
    logic                r_err;
    logic [XLEN-1:0]     r_rdata;
    logic [MEM_XLEN-1:0] w_mask;
    logic                w_misaligned;
    logic                w_accept;
    logic                w_access;

    mem_mask_gen u_mask_gen (
        .i_size       (mem_size_e'(req_size)),
        .i_addr_lo    (req_addr[2:0]),
        .o_mask       (w_mask),
        .o_misaligned (w_misaligned)
    );

    // Request capture payload; signed extension only applies to loads.
    always_comb begin
        w_accept         = (r_state == IDLE) && req_valid;
        w_acc_req.wen    = req_wen;
        w_acc_req.sgn_en = req_signed & ~req_wen;
        w_acc_req.mask   = w_mask;
        w_acc_req.addr   = MEM_XLEN'(req_addr);
        w_acc_req.wdata  = MEM_XLEN'(req_wdata);
    end

    // State and latency counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_misaligned) begin
                        w_state_nxt = RESP;
                    end else if (DIRECT_ACCESS) begin
                        w_state_nxt = ACCESS;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ACCESS: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs; the memory strobe is a state decode gated by reset so it can
    // only ever be a single clean cycle.
    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = r_rdata;
        resp_err      = r_err;
        mem_en        = 1'b0;
        mem_w_en      = 1'b0;
        mem_signed_en = 1'b0;
        mem_addr      = '0;
        mem_w_data    = '0;
        mem_r_mask    = '0;
        w_access      = (r_state == ACCESS) && !reset;
        if (r_state == IDLE) begin
            req_ready = 1'b1;
        end
        if (r_state == RESP) begin
            resp_valid = 1'b1;
        end
        if (w_access) begin
            mem_en        = 1'b1;
            mem_w_en      = r_acc.wen;
            mem_signed_en = r_acc.sgn_en;
            mem_addr      = XLEN'(r_acc.addr);
            mem_w_data    = XLEN'(r_acc.wdata);
            mem_r_mask    = XLEN'(r_acc.mask);
        end
    end

    // Request payload and response data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_acc   <= w_acc_req;
            r_err   <= w_misaligned;
            r_rdata <= '0;
        end else if (r_state == ACCESS) begin
            r_rdata <= r_acc.wen ? '0 : mem_r_data;
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: three instances (LATENCY 1, 4, 3) share a
// byte-addressed memory model; only the selected instance is ever active.
`timescale 1ns/1ps
module tb_mem_req_ctrl;

    localparam int ND = 3;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 3;
    endfunction

    typedef struct {
        logic        wen;
        logic        sgn;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_err;
        logic        exp_sen;
        logic [63:0] exp_mask;
        logic [63:0] exp_rdata;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [ND-1:0]     req_valid;
    logic              req_wen;
    logic              req_signed;
    logic [1:0]        req_size;
    logic [63:0]       req_addr;
    logic [63:0]       req_wdata;
    logic              resp_ready;
    logic [ND-1:0]     req_ready;
    logic [ND-1:0]     resp_valid;
    logic [ND-1:0]     resp_err;
    logic [ND-1:0]     mem_en;
    logic [ND-1:0]     mem_w_en;
    logic [ND-1:0]     mem_signed_en;
    logic [63:0]       resp_rdata [ND];
    logic [63:0]       mem_addr   [ND];
    logic [63:0]       mem_w_data [ND];
    logic [63:0]       mem_r_mask [ND];
    logic [63:0]       mem_r_data;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int sel      = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mem_req_ctrl #(.LATENCY(lat_of(g)), .XLEN(64)) u_dut (
            .clock         (clk),
            .reset         (reset),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_wen       (req_wen),
            .req_signed    (req_signed),
            .req_size      (req_size),
            .req_addr      (req_addr),
            .req_wdata     (req_wdata),
            .resp_valid    (resp_valid[g]),
            .resp_ready    (resp_ready),
            .resp_rdata    (resp_rdata[g]),
            .resp_err      (resp_err[g]),
            .mem_en        (mem_en[g]),
            .mem_w_en      (mem_w_en[g]),
            .mem_signed_en (mem_signed_en[g]),
            .mem_addr      (mem_addr[g]),
            .mem_w_data    (mem_w_data[g]),
            .mem_r_mask    (mem_r_mask[g]),
            .mem_r_data    (mem_r_data)
        );
    end

    // Memory model: 256 bytes indexed by addr[7:0], little-endian.
    logic [7:0]  mem [256];
    logic        mem_clr;
    logic        m_en, m_wen, m_sgn, rd_sb;
    logic [63:0] m_addr, m_mask, m_wdata, rd_raw;

    always_comb begin
        m_en    = mem_en[sel];
        m_wen   = mem_w_en[sel];
        m_sgn   = mem_signed_en[sel];
        m_addr  = mem_addr[sel];
        m_mask  = mem_r_mask[sel];
        m_wdata = mem_w_data[sel];
        rd_raw  = '0;
        for (int b = 0; b < 8; b++) rd_raw[b*8 +: 8] = mem[m_addr[7:0] + 8'(b)];
        rd_raw = rd_raw & m_mask;
        case (m_mask)
            64'hFF:        rd_sb = rd_raw[7];
            64'hFFFF:      rd_sb = rd_raw[15];
            64'hFFFF_FFFF: rd_sb = rd_raw[31];
            default:       rd_sb = rd_raw[63];
        endcase
        mem_r_data = !m_en ? 64'd0 : ((m_sgn && rd_sb) ? (rd_raw | ~m_mask) : rd_raw);
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (m_en && m_wen) begin
            for (int b = 0; b < 8; b++)
                if (m_mask[b*8]) mem[m_addr[7:0] + 8'(b)] <= m_wdata[b*8 +: 8];
        end
        if (|mem_en) en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // One full request/response transaction on DUT d, with an optional stall
    // of the response consumer.
    task automatic run_req(input string tag, input int d, input vec_t v, input int stall);
        int          lat, acc_n, resp_n, en0;
        logic        idle_leak, rdy_low, stable, a_wen, a_sen;
        logic [63:0] a_mask, a_addr, a_wdata, rd;
        logic        er;
        lat = lat_of(d);
        sel = d;
        @(negedge clk);
        chk({tag, " req_ready idle"}, 64'(req_ready[d]), 64'd1);
        req_wen      = v.wen;
        req_signed   = v.sgn;
        req_size     = v.size;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid[d] = 1'b1;
        en0          = en_cnt;
        @(negedge clk);
        // Scramble request inputs; the unit must ignore them from here on.
        req_valid[d] = 1'b0;
        req_addr     = ~v.addr;
        req_wdata    = ~v.wdata;
        req_size     = ~v.size;
        req_wen      = ~v.wen;
        acc_n = 0; resp_n = 0; idle_leak = 1'b0; rdy_low = 1'b1;
        a_wen = 1'b0; a_sen = 1'b0; a_mask = '0; a_addr = '0; a_wdata = '0;
        for (int n = 1; n <= 40 && resp_n == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (req_ready[d]) rdy_low = 1'b0;
            if (mem_en[d]) begin
                acc_n = n; a_wen = mem_w_en[d]; a_sen = mem_signed_en[d];
                a_mask = mem_r_mask[d]; a_addr = mem_addr[d]; a_wdata = mem_w_data[d];
            end else if (mem_w_en[d] || mem_signed_en[d] || (|mem_addr[d]) ||
                         (|mem_w_data[d]) || (|mem_r_mask[d])) begin
                idle_leak = 1'b1;
            end
            if (resp_valid[d]) resp_n = n;
        end
        chk({tag, " resp latency"}, 64'(resp_n), v.exp_err ? 64'd1 : 64'(lat + 1));
        chk({tag, " access cycle"}, 64'(acc_n), v.exp_err ? 64'd0 : 64'(lat));
        if (!v.exp_err) begin
            chk({tag, " r_mask"}, a_mask, v.exp_mask);
            chk({tag, " w_en"}, 64'(a_wen), 64'(v.wen));
            chk({tag, " signed_en"}, 64'(a_sen), 64'(v.exp_sen));
            chk({tag, " addr"}, a_addr, v.addr);
            chk({tag, " w_data"}, a_wdata, v.wdata);
        end
        chk({tag, " mem idle zero"}, 64'(idle_leak), 64'd0);
        chk({tag, " req_ready busy"}, 64'(rdy_low), 64'd1);
        rd = resp_rdata[d];
        er = resp_err[d];
        chk({tag, " resp_err"}, 64'(er), 64'(v.exp_err));
        chk({tag, " resp_rdata"}, rd, v.exp_rdata);
        if (stall > 0) begin
            stable = 1'b1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (!resp_valid[d] || req_ready[d] || resp_rdata[d] !== rd || resp_err[d] !== er)
                    stable = 1'b0;
            end
            chk({tag, " stall stable"}, 64'(stable), 64'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " resp_valid drop"}, 64'(resp_valid[d]), 64'd0);
        chk({tag, " req_ready back"}, 64'(req_ready[d]), 64'd1);
        chk({tag, " mem_en count"}, 64'(en_cnt - en0), v.exp_err ? 64'd0 : 64'd1);
    endtask

    vec_t vecs [16];
    vec_t hv;

    initial begin
        int   en0;
        logic saw_resp;
        //          wen   sgn   size   addr                    wdata                   err   sen   mask                    rdata
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 64'h0000_0000_8000_0004, 64'hCAFE_BABE_8000_0000, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0};
        vecs[1]  = '{1'b0, 1'b1, 2'd2, 64'h0000_0000_8000_0004, 64'h0,                   1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 64'h0000_0000_8000_0004, 64'h0,                   1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 64'h0000_0000_8000_0003, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 1'b0, 64'h0000_0000_0000_00FF, 64'h0};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 64'h0000_0000_8000_0003, 64'h0,                   1'b0, 1'b0, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00AB};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 64'h0000_0000_8000_0003, 64'h0,                   1'b0, 1'b1, 64'h0000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FFAB};
        vecs[6]  = '{1'b0, 1'b0, 2'd1, 64'h0000_0000_8000_0001, 64'h0,                   1'b1, 1'b0, 64'h0,                   64'h0};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 64'h0000_0000_8000_0002, 64'h0,                   1'b1, 1'b0, 64'h0,                   64'h0};
        vecs[8]  = '{1'b1, 1'b0, 2'd3, 64'h0000_0000_8000_0004, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 64'h0,                   64'h0};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 64'h0000_0000_8000_0004, 64'h0,                   1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[11] = '{1'b0, 1'b1, 2'd1, 64'h0000_0000_8000_000E, 64'h0,                   1'b0, 1'b1, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_1122};
        vecs[12] = '{1'b0, 1'b1, 2'd3, 64'h0000_0000_8000_0008, 64'h0,                   1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788};
        vecs[13] = '{1'b1, 1'b1, 2'd1, 64'h0000_0000_8000_0010, 64'h0000_0000_0000_8000, 1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h0};
        vecs[14] = '{1'b0, 1'b1, 2'd1, 64'h0000_0000_8000_0010, 64'h0,                   1'b0, 1'b1, 64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_8000};
        vecs[15] = '{1'b0, 1'b1, 2'd0, 64'h0000_0000_8000_0007, 64'h0,                   1'b0, 1'b1, 64'h0000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FF80};

        reset = 1'b1; mem_clr = 1'b1; req_valid = '0; resp_ready = 1'b0;
        req_wen = 1'b0; req_signed = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_clr = 1'b0;

        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst d%0d req_ready", d), 64'(req_ready[d]), 64'd1);
            chk($sformatf("rst d%0d resp_valid", d), 64'(resp_valid[d]), 64'd0);
            chk($sformatf("rst d%0d resp_err", d), 64'(resp_err[d]), 64'd0);
            chk($sformatf("rst d%0d resp_rdata", d), resp_rdata[d], 64'd0);
            chk($sformatf("rst d%0d mem_out", d),
                64'({mem_en[d], mem_w_en[d], mem_signed_en[d]}) | mem_addr[d] | mem_w_data[d] | mem_r_mask[d], 64'd0);
        end

        for (int i = 0; i < 16; i++) run_req($sformatf("v%0d", i), 0, vecs[i], 0);

        // LATENCY=4 dword load and a stalled misaligned response.
        run_req("lat4 dload", 1, vecs[12], 0);
        run_req("lat4 misal stall", 1, vecs[7], 3);

        // LATENCY=1 load with the consumer stalled for 10 cycles.
        run_req("lat1 stall10", 0, vecs[1], 10);

        // LATENCY=3 store killed by a one-cycle reset while waiting.
        sel = 2;
        en0 = en_cnt;
        @(negedge clk);
        chk("rstwait req_ready", 64'(req_ready[2]), 64'd1);
        req_wen = 1'b1; req_signed = 1'b0; req_size = 2'd2;
        req_addr = 64'h0000_0000_8000_0020; req_wdata = 64'h0000_0000_DEAD_BEEF;
        req_valid[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("rstwait busy", 64'(req_ready[2]), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        saw_resp = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid[2]) saw_resp = 1'b1;
        end
        chk("rstwait no mem_en", 64'(en_cnt - en0), 64'd0);
        chk("rstwait no resp", 64'(saw_resp), 64'd0);
        chk("rstwait idle", 64'(req_ready[2]), 64'd1);

        hv = '{1'b0, 1'b0, 2'd2, 64'h0000_0000_8000_0020, 64'h0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0};
        run_req("lat3 after rst", 2, hv, 0);
        run_req("lat3 dload", 2, vecs[12], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Initiator side of the simulated physical-memory interface: mem_en, w_en, signed_en, addr, w_data, r_mask in; r_data out.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Checks alignment and emits exactly one single-cycle memory access per legal request, after a programmable latency.
- Returns the load data, or a misalignment error, over a valid/ready response channel.

Parameters:
LATENCY, 1, cycles from request acceptance to the memory access cycle; legal range 1..15.
XLEN, 64, data/address width; fixed at 64 for this memory interface.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_wen  in  1  1 = store, 0 = load
req_signed  in  1  sign-extend load result
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
req_addr  in  64  byte address
req_wdata  in  64  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_rdata  out  64  load result, already masked/extended by memory; 0 for stores and errors
resp_err  out  1  misaligned request
mem_en  out  1  memory access strobe
mem_w_en  out  1  write strobe
mem_signed_en  out  1  sign-extend strobe
mem_addr  out  64  access address
mem_w_data  out  64  write data
mem_r_mask  out  64  size mask
mem_r_data  in  64  read data, combinational, valid in the same cycle as mem_en

Behaviour:
- One clock, `clock`. Reset is synchronous and active-high (`reset`). All state is cleared on the reset edge.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, all mem_* outputs=0.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture the request (call this edge T).
  - Aligned request with LATENCY=1: go to ACCESS.
  - Aligned request with LATENCY>1: go to WAIT with cnt=LATENCY-1.
  - Misaligned request (addr mod 2^size != 0): go to RESP with resp_err=1 and resp_rdata=0. No memory access is ever issued.
- WAIT: decrement cnt each cycle; go to ACCESS when cnt reaches 1.
- ACCESS: lasts exactly one cycle, which is cycle T+LATENCY.
  - mem_en=1.
  - mem_w_en=req_wen.
  - mem_signed_en=req_signed & ~req_wen.
  - mem_addr=req_addr.
  - mem_w_data=req_wdata.
  - mem_r_mask = 0xFF / 0xFFFF / 0xFFFF_FFFF / all-ones for size 0/1/2/3.
  - For a load, mem_r_data is registered into resp_rdata. For a store, resp_rdata=0.
  - Next state: RESP.
- mem_en is high only in ACCESS and is gated by ~reset combinationally. The memory model acts on every evaluation, so a double-length or glitching strobe duplicates writes and is forbidden.
- Outside ACCESS, all mem_* outputs are held at 0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until resp_ready.
  - On resp_ready, go to IDLE. req_ready rises on the following cycle; a new request cannot be accepted in the same cycle as the response handshake.
- Latency: a legal request's response is first visible at T+LATENCY+1. A misaligned request's response is first visible at T+1.
- req_ready=0 in WAIT, ACCESS and RESP. req_* inputs in those states are ignored.
- Reset during WAIT, ACCESS or RESP:
  - Return to IDLE; the pending response is dropped.
  - An access that is still in WAIT is never issued.
- resp_ready held low indefinitely: the unit stalls in RESP with no further memory traffic.

Decomposition:
- Shared package mem_pkg holds:
  - the size encoding enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the FSM state enum;
  - a size-to-mask function;
  - a size-alignment check function.
- Optional sub-module mem_mask_gen (size to mask plus misalignment flag), purely combinational. Everything else stays in mem_req_ctrl.

Test Plan:
- LATENCY=1, memory holds 0x80000000 at 0x80000004; signed word load from 0x80000004 -> exactly one mem_en cycle with r_mask=0xFFFFFFFF and signed_en=1; resp_rdata=0xFFFFFFFF80000000 at T+2.
- Byte store of 0xAB to 0x80000003 -> one mem_en cycle with w_en=1 and r_mask=0xFF; resp_valid, resp_err=0, resp_rdata=0; a subsequent byte load from the same address returns 0xAB.
- Half load from 0x80000001 -> mem_en never asserts; resp_valid at T+1 with resp_err=1 and resp_rdata=0.
- LATENCY=4, dword load -> mem_en high only at T+4; resp_valid at T+5; req_ready low from T+1 until the response handshake.
- resp_ready held low for 10 cycles -> resp_rdata/resp_err stable, no extra mem_en; the handshake returns the unit to IDLE and req_ready is high the next cycle.
- LATENCY=3; assert reset for one cycle during WAIT of a store -> no mem_en ever for that store, no response; the unit returns to IDLE and the next request completes normally.
